// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32IM pipeline: load-use, redirect, DMEM busywait
// and multi-cycle DIV/REM handling, plus a free-running stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int MULDIV_LAT = 32,
  parameter int CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [4:0]       ID_RS1,
  input  logic [4:0]       ID_RS2,
  input  logic             ID_USE_RS1,
  input  logic             ID_USE_RS2,
  input  logic [4:0]       IDEX_RD,
  input  logic             IDEX_MEMREAD,
  input  logic             IDEX_DIV,
  input  logic             EX_REDIRECT,
  input  logic             DMEM_BUSYWAIT,
  output logic             PC_EN,
  output logic             PC_SEL,
  output logic             IFID_EN,
  output logic             IFID_FLUSH,
  output logic             IDEX_EN,
  output logic             IDEX_FLUSH,
  output logic             EXMEM_EN,
  output logic             EXMEM_FLUSH,
  output logic             MEMWB_EN,
  output logic             MULDIV_DONE,
  output logic [CNT_W-1:0] STALL_COUNT
);

  localparam int DCW = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DIV_WAIT = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  state_t           saved_r;
  state_t           saved_s;
  state_t           eff_s;
  logic [DCW-1:0]   div_cnt_r;
  logic [DCW-1:0]   div_cnt_s;
  logic [CNT_W-1:0] stall_cnt_r;

  logic pc_en_s, pc_sel_s, ifid_en_s, ifid_flush_s, idex_en_s, idex_flush_s;
  logic exmem_en_s, exmem_flush_s, memwb_en_s, done_s;
  logic load_use_s;

  // A load in ID/EX whose non-zero rd feeds a source the ID instruction actually reads
  function automatic logic load_use_hazard(
    input logic       memread,
    input logic [4:0] rd,
    input logic       use1,
    input logic [4:0] rs1,
    input logic       use2,
    input logic [4:0] rs2
  );
    logic hit;
    hit = (use1 && (rs1 == rd)) || (use2 && (rs2 == rd));
    return memread && (rd != 5'd0) && hit;
  endfunction

  assign load_use_s = load_use_hazard(IDEX_MEMREAD, IDEX_RD, ID_USE_RS1, ID_RS1,
                                      ID_USE_RS2, ID_RS2);

  // The cycle busywait drops is evaluated as if already back in the saved state
  assign eff_s = (state_r == MEM_WAIT) ? saved_r : state_r;

  // Next-state and pipeline-control decode, priority busywait > DIV > redirect > load-use
  always_comb begin
    pc_en_s       = 1'b1;
    pc_sel_s      = 1'b0;
    ifid_en_s     = 1'b1;
    ifid_flush_s  = 1'b0;
    idex_en_s     = 1'b1;
    idex_flush_s  = 1'b0;
    exmem_en_s    = 1'b1;
    exmem_flush_s = 1'b0;
    memwb_en_s    = 1'b1;
    done_s        = 1'b0;
    state_s       = state_r;
    saved_s       = saved_r;
    div_cnt_s     = div_cnt_r;

    if (!RESET_N) begin
      pc_en_s       = 1'b0;
      ifid_en_s     = 1'b0;
      ifid_flush_s  = 1'b1;
      idex_en_s     = 1'b0;
      idex_flush_s  = 1'b1;
      exmem_en_s    = 1'b0;
      exmem_flush_s = 1'b1;
      memwb_en_s    = 1'b0;
      state_s       = RUN;
      saved_s       = RUN;
      div_cnt_s     = {DCW{1'b0}};
    end else if (DMEM_BUSYWAIT) begin
      pc_en_s    = 1'b0;
      ifid_en_s  = 1'b0;
      idex_en_s  = 1'b0;
      exmem_en_s = 1'b0;
      memwb_en_s = 1'b0;
      state_s    = MEM_WAIT;
      saved_s    = eff_s;
    end else begin
      case (eff_s)
        DIV_WAIT: begin
          if (div_cnt_r == {DCW{1'b0}}) begin
            done_s  = 1'b1;
            state_s = RUN;
          end else begin
            pc_en_s       = 1'b0;
            ifid_en_s     = 1'b0;
            idex_en_s     = 1'b0;
            exmem_flush_s = 1'b1;
            div_cnt_s     = div_cnt_r - DCW'(1'b1);
            state_s       = DIV_WAIT;
          end
        end
        RUN: begin
          state_s = RUN;
          if (IDEX_DIV) begin
            pc_en_s       = 1'b0;
            ifid_en_s     = 1'b0;
            idex_en_s     = 1'b0;
            exmem_flush_s = 1'b1;
            div_cnt_s     = DCW'(MULDIV_LAT - 2);
            state_s       = DIV_WAIT;
          end else if (EX_REDIRECT) begin
            pc_sel_s     = 1'b1;
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
          end else if (load_use_s) begin
            pc_en_s      = 1'b0;
            ifid_en_s    = 1'b0;
            idex_flush_s = 1'b1;
          end else begin
            pc_sel_s = 1'b0;
          end
        end
        default: begin
          state_s = RUN;
        end
      endcase
    end
  end

  // Sequencer state, saved return state and DIV occupancy counter
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r   <= RUN;
      saved_r   <= RUN;
      div_cnt_r <= {DCW{1'b0}};
    end else begin
      state_r   <= state_s;
      saved_r   <= saved_s;
      div_cnt_r <= div_cnt_s;
    end
  end

  // Stall-cycle performance counter, wraps naturally
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (!pc_en_s) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign PC_EN       = pc_en_s;
  assign PC_SEL      = pc_sel_s;
  assign IFID_EN     = ifid_en_s;
  assign IFID_FLUSH  = ifid_flush_s;
  assign IDEX_EN     = idex_en_s;
  assign IDEX_FLUSH  = idex_flush_s;
  assign EXMEM_EN    = exmem_en_s;
  assign EXMEM_FLUSH = exmem_flush_s;
  assign MEMWB_EN    = memwb_en_s;
  assign MULDIV_DONE = done_s;
  assign STALL_COUNT = stall_cnt_r;

endmodule
